// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and helpers for the 7-segment scan controller
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Hex glyphs, bit order gfedcba, active-high
  localparam logic [6:0] GLYPH_TABLE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bits needed to count 0..v-1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - nibble to gfedcba segment decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_in,
  output logic [6:0] seg_out
);

  // Pure table lookup
  always_comb begin
    seg_out = GLYPH_TABLE[nibble_in];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed multi-digit 7-segment scan controller with frame-aligned loads
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 8250,
  parameter int BLANK_CYC = 33
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  zero_supp,
  output logic                  load_ack,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_pulse
);

  localparam int CNT_MAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam int IDX_W   = clog2(DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wrap;

  logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0]   stage_val_q, stage_val_d;
  logic [DIGITS-1:0]     stage_dp_q, stage_dp_d;
  logic                  pending_q, pending_d;

  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     digit_en_q, digit_en_d;
  logic                  load_ack_q, load_ack_d;
  logic                  frame_pulse_q, frame_pulse_d;

  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  supp_sel;
  logic [DIGITS-1:0]     supp_vec;
  logic                  run_zero;
  logic [6:0]            glyph;

  // Scan state register: state, dwell counter and digit index
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: dwell BLANK_CYC in BLANK, TICK_DIV in SHOW, advance digit on leaving SHOW
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == TICK_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Load staging; shadow only changes at the wrap so a frame never mixes old and new values
  always_comb begin
    stage_val_d  = stage_val_q;
    stage_dp_d   = stage_dp_q;
    pending_d    = pending_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    load_ack_d   = 1'b0;
    if (load) begin
      stage_val_d = value_in;
      stage_dp_d  = dp_in;
      pending_d   = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        shadow_val_d = value_in;
        shadow_dp_d  = dp_in;
        pending_d    = 1'b0;
        load_ack_d   = 1'b1;
      end else if (pending_q) begin
        shadow_val_d = stage_val_q;
        shadow_dp_d  = stage_dp_q;
        pending_d    = 1'b0;
        load_ack_d   = 1'b1;
      end
    end
  end

  // Load datapath registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      stage_val_q  <= '0;
      stage_dp_q   <= '0;
      pending_q    <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
    end else begin
      stage_val_q  <= stage_val_d;
      stage_dp_q   <= stage_dp_d;
      pending_q    <= pending_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
    end
  end

  // Leading-zero mask: a digit is blankable when it and every digit above it are zero
  always_comb begin
    supp_vec = '0;
    run_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run_zero    = run_zero & (shadow_val_q[4*k +: 4] == 4'h0);
      supp_vec[k] = run_zero & (k != 0);
    end
  end

  // Select nibble, dp and suppression flag of the digit about to be shown
  always_comb begin
    nib_sel  = 4'h0;
    dp_sel   = 1'b0;
    supp_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib_sel  = shadow_val_q[4*k +: 4];
        dp_sel   = shadow_dp_q[k];
        supp_sel = supp_vec[k];
      end
    end
  end

  seg7_decode u_decode (
    .nibble_in (nib_sel),
    .seg_out   (glyph)
  );

  // Output decode from the next state so registered outputs change on the entering edge
  always_comb begin
    seg_d         = SEG_OFF;
    digit_en_d    = '0;
    frame_pulse_d = wrap;
    if (state_d == SHOW) begin
      digit_en_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
      seg_d      = {dp_sel, (zero_supp && supp_sel) ? 7'h00 : glyph};
    end
  end

  // Registered outputs
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      seg_q         <= SEG_OFF;
      digit_en_q    <= '0;
      load_ack_q    <= 1'b0;
      frame_pulse_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      digit_en_q    <= digit_en_d;
      load_ack_q    <= load_ack_d;
      frame_pulse_q <= frame_pulse_d;
    end
  end

  assign seg_out     = seg_q;
  assign digit_en    = digit_en_q;
  assign load_ack    = load_ack_q;
  assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  logic        clk_in;
  logic        reset;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        zero_supp;
  logic        load_ack;
  logic [7:0]  seg_out;
  logic [3:0]  digit_en;
  logic        frame_pulse;

  int checks;
  int failures;
  int cyc;
  int acks;

  seg7_scan_ctrl #(
    .DIGITS    (4),
    .TICK_DIV  (4),
    .BLANK_CYC (2)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .load        (load),
    .zero_supp   (zero_supp),
    .load_ack    (load_ack),
    .seg_out     (seg_out),
    .digit_en    (digit_en),
    .frame_pulse (frame_pulse)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // One clock: observe at the falling edge
  task automatic tick();
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    load     = 1'b1;
    value_in = v;
    dp_in    = dp;
    tick();
    load     = 1'b0;
  endtask

  // Frame length 24, digit k lit at 24f+6k+2 .. 24f+6k+5
  task automatic chk_digit(input string tag, input int f, input int k, input logic [7:0] exp_seg);
    goto(24 * f + 6 * k + 3);
    chk({tag, "_en"}, 32'(digit_en), 32'(4'b0001 << k));
    chk({tag, "_seg"}, 32'(seg_out), 32'(exp_seg));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    acks      = 0;
    reset     = 1'b1;
    value_in  = 16'h0;
    dp_in     = 4'h0;
    load      = 1'b0;
    zero_supp = 1'b0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    cyc   = 0;

    // 1: reset state and first scan
    chk("rst_seg", 32'(seg_out), 32'h00);
    chk("rst_en", 32'(digit_en), 32'h0);
    chk("rst_ack", 32'(load_ack), 32'h0);
    chk("rst_fp", 32'(frame_pulse), 32'h0);
    goto(1);
    chk("c1_en", 32'(digit_en), 32'h0);
    goto(2);
    chk("c2_en", 32'(digit_en), 32'h1);
    chk("c2_seg", 32'(seg_out), 32'h3F);
    goto(5);
    chk("c5_en", 32'(digit_en), 32'h1);
    chk("c5_seg", 32'(seg_out), 32'h3F);
    goto(6);
    chk("c6_blank_en", 32'(digit_en), 32'h0);
    chk("c6_blank_seg", 32'(seg_out), 32'h00);
    goto(8);
    chk("c8_en", 32'(digit_en), 32'h2);
    goto(23);
    chk("c23_fp", 32'(frame_pulse), 32'h0);
    goto(24);
    chk("c24_fp", 32'(frame_pulse), 32'h1);
    chk("c24_en", 32'(digit_en), 32'h0);
    goto(25);
    chk("c25_fp", 32'(frame_pulse), 32'h0);

    // 2: mid-frame load held until wrap
    goto(30);
    do_load(16'h1234, 4'b0000);
    goto(32);
    chk("old_val_seg", 32'(seg_out), 32'h3F);
    goto(40);
    chk("no_early_ack", 32'(load_ack), 32'h0);
    goto(48);
    chk("wrap2_fp", 32'(frame_pulse), 32'h1);
    chk("wrap2_ack", 32'(load_ack), 32'h1);
    goto(49);
    chk("ack2_one_cycle", 32'(load_ack), 32'h0);
    chk_digit("f2_d0", 2, 0, 8'h66);
    chk_digit("f2_d1", 2, 1, 8'h4F);
    chk_digit("f2_d2", 2, 2, 8'h5B);
    chk_digit("f2_d3", 2, 3, 8'h06);

    // 3: leading-zero suppression with dp kept
    goto(60);
    zero_supp = 1'b1;
    do_load(16'h0040, 4'b0100);
    goto(72);
    chk("wrap3_ack", 32'(load_ack), 32'h1);
    chk_digit("f3_d0", 3, 0, 8'h3F);
    chk_digit("f3_d1", 3, 1, 8'h66);
    chk_digit("f3_d2", 3, 2, 8'h80);
    chk_digit("f3_d3", 3, 3, 8'h00);

    // 4: two loads in one frame, last wins, one ack
    goto(96);
    zero_supp = 1'b0;
    dp_in     = 4'b0000;
    acks      = 0;
    while (cyc < 120) begin
      tick();
      if (load_ack) acks++;
      load = 1'b0;
      if (cyc == 100) begin
        load     = 1'b1;
        value_in = 16'h1111;
      end
      if (cyc == 110) begin
        load     = 1'b1;
        value_in = 16'h2222;
      end
    end
    load = 1'b0;
    chk("single_ack_count", 32'(acks), 32'd1);
    chk("wrap5_ack", 32'(load_ack), 32'h1);
    chk_digit("f5_d0", 5, 0, 8'h5B);
    chk_digit("f5_d1", 5, 1, 8'h5B);
    chk_digit("f5_d2", 5, 2, 8'h5B);
    chk_digit("f5_d3", 5, 3, 8'h5B);

    // 5: load sampled on the wrap edge itself bypasses staging
    goto(143);
    do_load(16'hABCD, 4'b0000);
    chk("bypass_ack", 32'(load_ack), 32'h1);
    chk("bypass_fp", 32'(frame_pulse), 32'h1);
    chk_digit("f6_d0", 6, 0, 8'h5E);
    chk_digit("f6_d1", 6, 1, 8'h39);
    chk_digit("f6_d2", 6, 2, 8'h7C);
    chk_digit("f6_d3", 6, 3, 8'h77);

    // 6: asynchronous reset during digit 2 with a pending load
    goto(174);
    do_load(16'h5555, 4'b1111);
    goto(183);
    chk("pre_rst_en", 32'(digit_en), 32'h4);
    chk("pre_rst_seg", 32'(seg_out), 32'h7C);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_seg", 32'(seg_out), 32'h00);
    chk("async_rst_en", 32'(digit_en), 32'h0);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    cyc   = 0;
    chk("rst2_ack", 32'(load_ack), 32'h0);
    acks = 0;
    while (cyc < 26) begin
      tick();
      if (load_ack) acks++;
      if (cyc == 2) begin
        chk("rst2_c2_en", 32'(digit_en), 32'h1);
        chk("rst2_c2_seg", 32'(seg_out), 32'h3F);
      end
      if (cyc == 24) begin
        chk("rst2_fp", 32'(frame_pulse), 32'h1);
      end
    end
    chk("rst2_no_ack", 32'(acks), 32'd0);
    chk_digit("rst2_f1_d3", 1, 3, 8'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-cathode multi-digit 7-segment display.
- Holds a DIGITS-nibble display value and drives one digit at a time through a nibble-to-segment decoder.
- Inserts a blanking gap between digits to prevent ghosting.
- Accepts new display values through a load/ack handshake, applied only at frame boundaries so no tearing is visible.
- Sits between the CPU output port (or debug register) and the board display pins.

Parameters:
- DIGITS, 4: number of digits scanned; must be ≥2.
- TICK_DIV, 8250: clk_in cycles each digit is lit (about 4 kHz per digit at 33 MHz).
- BLANK_CYC, 33: clk_in cycles with all digits off before each digit is lit; must be ≥1.

Ports:
- clk_in, in, 1: single system clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- value_in, in, 4*DIGITS: display value; nibble k maps to digit k, and digit 0 is the rightmost.
- dp_in, in, DIGITS: decimal-point mask, sampled together with value_in.
- load, in, 1: request to capture value_in and dp_in.
- zero_supp, in, 1: level input; 1 enables leading-zero suppression.
- load_ack, out, 1: one-cycle pulse when the captured value becomes visible.
- seg_out, out, 8: bit 7 is dp; bits 6..0 are segments g..a; active-high.
- digit_en, out, DIGITS: one-hot digit enable, active-high.
- frame_pulse, out, 1: one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: seg_out=0, digit_en=0, load_ack=0, frame_pulse=0.
  - Internal state: shadow value and shadow dp=0, staging=0, pending=0, idx=0, cnt=0, state=BLANK.
- FSM has two states, BLANK and SHOW:
  - BLANK: digit_en=0 and seg_out=0 for BLANK_CYC cycles, then go to SHOW.
  - SHOW: digit_en=onehot(idx) and seg_out={dp, decode(nibble[idx])} for TICK_DIV cycles, then go to BLANK with idx+1.
- Outputs are registered. They change on the clk_in edge that enters a state and are stable for the full state duration.
- Wrap: leaving SHOW with idx=DIGITS-1 sets idx=0 and drives frame_pulse=1 for that one cycle (the first BLANK cycle of the new frame).
- One frame lasts DIGITS*(BLANK_CYC+TICK_DIV) cycles.
- Load handling:
  - Any cycle with load=1 copies value_in/dp_in into staging and sets pending.
  - Several loads within one frame: the last one wins, and only one ack is issued.
- Transfer at wrap:
  - If pending=1, shadow takes staging, pending clears, and load_ack pulses in the same cycle as frame_pulse.
  - If load=1 in the wrap cycle itself, value_in/dp_in bypass staging into shadow and the ack is issued in that cycle.
- Decode: 0-F use standard hex glyphs in gfedcba order:
  - 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Leading-zero suppression (zero_supp=1):
  - Every digit above the most-significant nonzero nibble gets segment bits 6..0 forced to 0.
  - Digit 0 is never suppressed.
  - dp is still shown if set.
  - digit_en still follows the scan.
  - zero_supp is sampled each cycle; there is no frame alignment.
- Counters:
  - cnt width is clog2(max(TICK_DIV,BLANK_CYC)). It reloads to 0 on every state change.
  - idx width is clog2(DIGITS) and wraps explicitly at DIGITS-1, not at a power of two.
- Reset mid-operation: outputs clear immediately and any pending load is discarded. The scan restarts with BLANK on digit 0.

Decomposition:
- Package seg7_pkg contents:
  - state enum {BLANK, SHOW}.
  - SEG_OFF=8'h00.
  - 16-entry glyph constant table.
  - clog2 helper function.
- Sub-module seg7_decode: purely combinational, 4-bit nibble in, 7-bit gfedcba out, using the package table.
- The controller instantiates one seg7_decode on the idx-selected nibble.

Test Plan (bench parameters: DIGITS=4, TICK_DIV=4, BLANK_CYC=2; frame = 24 cycles):
1. Release reset with shadow=0:
   - Cycles 0-1: digit_en=0000.
   - Cycles 2-5: digit_en=0001, seg_out=0x3F.
   - digit 1 is lit from cycle 8 onward.
   - frame_pulse first occurs at cycle 24.
2. Pulse load with value_in=0x1234 and dp_in=0000 mid-frame:
   - Old value remains displayed until the wrap.
   - load_ack coincides with frame_pulse.
   - Next frame: digit0=0x66, digit1=0x4F, digit2=0x5B, digit3=0x06.
3. Load 0x0040 with zero_supp=1 and dp_in=0100:
   - digit3=0x00.
   - digit2=0x80 (suppressed, dp still shown).
   - digit1=0x66.
   - digit0=0x3F.
4. Load 0x1111, then 0x2222 within the same frame:
   - Exactly one load_ack.
   - The next frame shows 0x5B on all four digits.
5. Load 0xABCD asserted exactly in the wrap cycle:
   - load_ack occurs in that cycle.
   - The following frame shows digit0=0x5E and digit3=0x77.
6. Assert reset during SHOW of digit 2, between clock edges:
   - seg_out and digit_en go to 0 without waiting for a clock edge.
   - No load_ack follows.
   - After release, the scan restarts at digit 0 with shadow=0.
